type2_mm_rd_sched: RTL and testbench

Round-robin read scheduler for the four TYPE2 receive frame buffers. It sits in the `clk_100m` domain between the MMRX buffer read port (`rd_sel`/`rd_port`/`rd_addr`/`rd_data`, `rd_dmm_empty`) and a downstream frame consumer. It picks a non-empty port, reads the length header and then the frame body, streams the body out with SOF/EOF framing, and releases the buffer. It replaces per-port software polling of the read port.

---
 rtl/type2_mm_rd_sched_if.sv | 32 +++
 rtl/type2_mm_rd_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_type2_mm_rd_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/type2_mm_rd_sched_if.sv
// Bus bundle between the TYPE2 round-robin read scheduler, the MMRX buffer
// read port and the downstream frame consumer.
interface type2_mm_rd_sched_if;
  logic        enable;
  logic [3:0]  rd_dmm_empty;
  logic        frm_ready;
  logic [17:0] rd_data;
  logic        rd_sel;
  logic [1:0]  rd_port;
  logic [8:0]  rd_addr;
  logic        frm_dval;
  logic [17:0] frm_data;
  logic        frm_sof;
  logic        frm_eof;
  logic [1:0]  frm_port;
  logic        rd_done;
  logic [1:0]  rd_done_port;
  logic        len_err;
  logic        busy;

  modport master (
    input  enable, rd_dmm_empty, frm_ready, rd_data,
    output rd_sel, rd_port, rd_addr, frm_dval, frm_data, frm_sof, frm_eof,
           frm_port, rd_done, rd_done_port, len_err, busy
  );

  modport slave (
    output enable, rd_dmm_empty, frm_ready, rd_data,
    input  rd_sel, rd_port, rd_addr, frm_dval, frm_data, frm_sof, frm_eof,
           frm_port, rd_done, rd_done_port, len_err, busy
  );
endinterface

// File: rtl/type2_mm_rd_sched.sv
// Round-robin read scheduler for the four TYPE2 receive frame buffers.
// Picks a non-empty port, reads the length header at addr 0, streams body
// words 1..L out with SOF/EOF framing and releases the buffer with rd_done.
module type2_mm_rd_sched #(
  parameter int RD_LAT  = 2,
  parameter int MAX_LEN = 256
) (
  input logic                 clk_100m,
  input logic                 rst_100m,
  type2_mm_rd_sched_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_HWAIT = 3'd2;
  localparam logic [2:0] S_BODY  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  localparam logic [2:0] RD_LAT_W  = 3'(RD_LAT);
  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  logic [2:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [8:0]        len_q, len_d;
  logic              rd_sel_q, rd_sel_d;
  logic [1:0]        rd_port_q, rd_port_d;
  logic [8:0]        rd_addr_q, rd_addr_d;
  logic              iss_body_q, iss_body_d;
  logic              iss_sof_q, iss_sof_d;
  logic              iss_eof_q, iss_eof_d;
  logic [RD_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [RD_LAT-1:0] sr_sof_q, sr_sof_d;
  logic [RD_LAT-1:0] sr_eof_q, sr_eof_d;
  logic              frm_dval_q, frm_dval_d;
  logic [17:0]       frm_data_q, frm_data_d;
  logic              frm_sof_q, frm_sof_d;
  logic              frm_eof_q, frm_eof_d;
  logic [1:0]        frm_port_q, frm_port_d;
  logic              rd_done_q, rd_done_d;
  logic [1:0]        rd_done_port_q, rd_done_port_d;
  logic              len_err_q, len_err_d;
  logic              busy_q, busy_d;

  logic              grant_vld;
  logic [1:0]        grant_port;
  logic [1:0]        idx;
  logic [8:0]        hdr_len;
  logic              hdr_bad;
  logic [8:0]        addr_inc;

  assign hdr_len  = bus.rd_data[8:0];
  assign hdr_bad  = (hdr_len == 9'd0) || (hdr_len > MAX_LEN_W);
  assign addr_inc = rd_addr_q + 9'd1;

  // Round-robin search: first non-empty port at or after ptr wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = ptr_q;
    idx        = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (!bus.rd_dmm_empty[idx]) begin
        grant_vld  = 1'b1;
        grant_port = idx;
      end
    end
  end

  // Frame FSM: header fetch, length check, body address issue, release.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    wcnt_d         = wcnt_q;
    len_d          = len_q;
    rd_sel_d       = 1'b0;
    rd_port_d      = rd_port_q;
    rd_addr_d      = 9'd0;
    iss_body_d     = 1'b0;
    iss_sof_d      = 1'b0;
    iss_eof_d      = 1'b0;
    rd_done_d      = 1'b0;
    rd_done_port_d = rd_done_port_q;
    len_err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && bus.frm_ready && grant_vld) begin
          state_d   = S_HDR;
          rd_port_d = grant_port;
        end
      end
      S_HDR: begin
        rd_sel_d = 1'b1;
        wcnt_d   = 3'd0;
        state_d  = S_HWAIT;
      end
      S_HWAIT: begin
        if (wcnt_q == RD_LAT_W) begin
          if (hdr_bad) begin
            state_d        = S_ERR;
            len_err_d      = 1'b1;
            rd_done_d      = 1'b1;
            rd_done_port_d = rd_port_q;
          end else begin
            // The header sample cycle already issues body word 1.
            len_d      = hdr_len;
            rd_sel_d   = 1'b1;
            rd_addr_d  = 9'd1;
            iss_body_d = 1'b1;
            iss_sof_d  = 1'b1;
            iss_eof_d  = (hdr_len == 9'd1);
            state_d    = (hdr_len == 9'd1) ? S_DRAIN : S_BODY;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_BODY: begin
        rd_sel_d   = 1'b1;
        rd_addr_d  = addr_inc;
        iss_body_d = 1'b1;
        iss_eof_d  = (addr_inc == len_q);
        if (addr_inc == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (frm_eof_q) begin
          state_d        = S_DONE;
          rd_done_d      = 1'b1;
          rd_done_port_d = rd_port_q;
        end
      end
      S_DONE, S_ERR: begin
        ptr_d   = rd_port_q + 2'd1;
        state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid/framing shift register aligning issued addresses with rd_data.
  always_comb begin
    sr_vld_d    = sr_vld_q;
    sr_sof_d    = sr_sof_q;
    sr_eof_d    = sr_eof_q;
    sr_vld_d[0] = iss_body_q;
    sr_sof_d[0] = iss_body_q & iss_sof_q;
    sr_eof_d[0] = iss_body_q & iss_eof_q;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_vld_d[i] = sr_vld_q[i-1];
      sr_sof_d[i] = sr_sof_q[i-1];
      sr_eof_d[i] = sr_eof_q[i-1];
    end
    frm_dval_d = sr_vld_q[RD_LAT-1];
    frm_sof_d  = sr_vld_q[RD_LAT-1] & sr_sof_q[RD_LAT-1];
    frm_eof_d  = sr_vld_q[RD_LAT-1] & sr_eof_q[RD_LAT-1];
    frm_data_d = sr_vld_q[RD_LAT-1] ? bus.rd_data : frm_data_q;
    frm_port_d = sr_vld_q[RD_LAT-1] ? rd_port_q : frm_port_q;
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything, including data.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state_q        <= S_IDLE;
      ptr_q          <= 2'd0;
      wcnt_q         <= 3'd0;
      len_q          <= 9'd0;
      rd_sel_q       <= 1'b0;
      rd_port_q      <= 2'd0;
      rd_addr_q      <= 9'd0;
      iss_body_q     <= 1'b0;
      iss_sof_q      <= 1'b0;
      iss_eof_q      <= 1'b0;
      sr_vld_q       <= '0;
      sr_sof_q       <= '0;
      sr_eof_q       <= '0;
      frm_dval_q     <= 1'b0;
      frm_data_q     <= 18'd0;
      frm_sof_q      <= 1'b0;
      frm_eof_q      <= 1'b0;
      frm_port_q     <= 2'd0;
      rd_done_q      <= 1'b0;
      rd_done_port_q <= 2'd0;
      len_err_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      wcnt_q         <= wcnt_d;
      len_q          <= len_d;
      rd_sel_q       <= rd_sel_d;
      rd_port_q      <= rd_port_d;
      rd_addr_q      <= rd_addr_d;
      iss_body_q     <= iss_body_d;
      iss_sof_q      <= iss_sof_d;
      iss_eof_q      <= iss_eof_d;
      sr_vld_q       <= sr_vld_d;
      sr_sof_q       <= sr_sof_d;
      sr_eof_q       <= sr_eof_d;
      frm_dval_q     <= frm_dval_d;
      frm_data_q     <= frm_data_d;
      frm_sof_q      <= frm_sof_d;
      frm_eof_q      <= frm_eof_d;
      frm_port_q     <= frm_port_d;
      rd_done_q      <= rd_done_d;
      rd_done_port_q <= rd_done_port_d;
      len_err_q      <= len_err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.rd_sel       = rd_sel_q;
  assign bus.rd_port      = rd_port_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.frm_dval     = frm_dval_q;
  assign bus.frm_data     = frm_data_q;
  assign bus.frm_sof      = frm_sof_q;
  assign bus.frm_eof      = frm_eof_q;
  assign bus.frm_port     = frm_port_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.rd_done_port = rd_done_port_q;
  assign bus.len_err      = len_err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_type2_mm_rd_sched.sv
// Directed bench for type2_mm_rd_sched with a 4-port buffer memory model.
module tb_type2_mm_rd_sched;
  localparam int RD_LAT  = 2;
  localparam int MAX_LEN = 256;

  logic clk_100m = 1'b0;
  logic rst_100m;

  type2_mm_rd_sched_if bus();

  type2_mm_rd_sched #(.RD_LAT(RD_LAT), .MAX_LEN(MAX_LEN)) dut (
    .clk_100m (clk_100m),
    .rst_100m (rst_100m),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  // Buffer memory with RD_LAT cycles from registered address to data.
  logic [17:0] mem [4][512];
  logic [17:0] pipe [RD_LAT];
  always @(posedge clk_100m) begin
    pipe[0] <= mem[bus.rd_port][bus.rd_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[RD_LAT-1];

  typedef struct {
    logic [17:0] d;
    logic        sof;
    logic        eof;
    logic [1:0]  port;
    int          cyc;
  } word_t;

  word_t fq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample after the edge, collect words, release served buffers.
  task automatic tick();
    @(posedge clk_100m);
    #1;
    cyc++;
    if (bus.frm_dval === 1'b1)
      fq.push_back('{d: bus.frm_data, sof: bus.frm_sof, eof: bus.frm_eof,
                     port: bus.frm_port, cyc: cyc});
    if (bus.rd_done === 1'b1) bus.rd_dmm_empty[bus.rd_done_port] = 1'b1;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_port, input logic exp_err);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.rd_done !== 1'b1 && n < 2000);
    chk({tag, " in time"}, 64'(n < 2000), 64'd1);
    chk({tag, " port"}, 64'(bus.rd_done_port), 64'(exp_port));
    chk({tag, " len_err"}, 64'(bus.len_err), 64'(exp_err));
  endtask

  task automatic chk_frame(input string tag, input int port, input int len);
    int bad = 0;
    chk({tag, " words"}, 64'(fq.size()), 64'(len));
    foreach (fq[i]) begin
      if (fq[i].d !== mem[port][i+1] || fq[i].sof !== (i == 0) ||
          fq[i].eof !== (i == len - 1) || fq[i].port !== 2'(port) ||
          fq[i].cyc != fq[0].cyc + i)
        bad++;
    end
    chk({tag, " content"}, 64'(bad), 64'd0);
    fq.delete();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.rd_sel, bus.rd_port, bus.rd_addr, bus.frm_dval, bus.frm_data,
                bus.frm_sof, bus.frm_eof, bus.frm_port, bus.rd_done,
                bus.rd_done_port, bus.len_err, bus.busy});
  endfunction

  initial begin
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 512; a++)
        mem[p][a] = {2'(p), 16'(a ^ 32'h5A5A)};
    rst_100m         = 1'b1;
    bus.enable       = 1'b0;
    bus.frm_ready    = 1'b0;
    bus.rd_dmm_empty = 4'hF;
    tick();
    tick();
    chk("reset outputs", all_outs(), 64'd0);
    rst_100m      = 1'b0;
    bus.enable    = 1'b1;
    bus.frm_ready = 1'b1;

    // Port 2, L = 3: exact cycle timing.
    mem[2][0] = 18'd3;
    tick();
    chk("idle busy", 64'(bus.busy), 64'd0);
    bus.rd_dmm_empty = 4'b1011;
    tick();
    chk("t1 hdr sel", 64'({bus.rd_sel, bus.busy, bus.rd_port}), 64'({1'b0, 1'b1, 2'd2}));
    tick();
    chk("t1 G addr0", 64'({bus.rd_sel, bus.rd_addr}), 64'({1'b1, 9'd0}));
    tick();
    chk("t1 G+1 sel", 64'(bus.rd_sel), 64'd0);
    tick();
    chk("t1 G+2 sel", 64'(bus.rd_sel), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1 body addr", 64'({bus.rd_sel, bus.rd_addr}), 64'({1'b1, 9'(k)}));
    end
    tick();
    chk("t1 G+6 frm", 64'({bus.rd_sel, bus.frm_dval, bus.frm_sof, bus.frm_eof, bus.frm_data}),
        64'({1'b0, 3'b110, mem[2][1]}));
    tick();
    chk("t1 G+7 frm", 64'({bus.frm_dval, bus.frm_sof, bus.frm_eof}), 64'(3'b100));
    tick();
    chk("t1 G+8 frm", 64'({bus.frm_dval, bus.frm_sof, bus.frm_eof, bus.frm_data}),
        64'({3'b101, mem[2][3]}));
    tick();
    chk("t1 G+9 done", 64'({bus.rd_done, bus.rd_done_port, bus.frm_dval, bus.len_err}),
        64'({1'b1, 2'd2, 1'b0, 1'b0}));
    tick();
    chk("t1 G+10 busy", 64'(bus.busy), 64'd1);
    tick();
    chk("t1 G+11 busy", 64'(bus.busy), 64'd0);
    chk_frame("t1 frame", 2, 3);

    // All four ports full, L = 1 each: round-robin order.
    rst_100m = 1'b1;
    tick();
    rst_100m = 1'b0;
    for (int p = 0; p < 4; p++) mem[p][0] = 18'd1;
    bus.rd_dmm_empty = 4'h0;
    for (int p = 0; p < 4; p++) begin
      wait_done("t2 rr", 2'(p), 1'b0);
      chk_frame("t2 frame", p, 1);
    end
    bus.rd_dmm_empty[0] = 1'b0;
    wait_done("t2 wrap", 2'd0, 1'b0);
    chk_frame("t2 wrap frame", 0, 1);
    bus.rd_dmm_empty = 4'b0100;
    wait_done("t2 p1", 2'd1, 1'b0);
    wait_done("t2 skip to p3", 2'd3, 1'b0);
    wait_done("t2 then p0", 2'd0, 1'b0);
    fq.delete();

    // Illegal headers: L = 0 on port 1, then L = 300 on port 2.
    repeat (3) tick();
    mem[1][0] = 18'd0;
    bus.rd_dmm_empty = 4'b1101;
    tick();
    tick();
    chk("t3 G port1", 64'({bus.rd_sel, bus.rd_addr, bus.rd_port}), 64'({1'b1, 9'd0, 2'd1}));
    tick();
    tick();
    chk("t3 G+2 quiet", 64'({bus.len_err, bus.rd_done}), 64'd0);
    tick();
    chk("t3 L0 err", 64'({bus.len_err, bus.rd_done, bus.rd_done_port}), 64'({2'b11, 2'd1}));
    tick();
    chk("t3 err pulse", 64'({bus.len_err, bus.rd_done}), 64'd0);
    repeat (3) tick();
    chk("t3 no frm", 64'(fq.size()), 64'd0);
    mem[2][0] = 18'd300;
    mem[1][0] = 18'd1;
    bus.rd_dmm_empty = 4'b1001;
    tick();
    tick();
    chk("t3 G ptr advanced", 64'({bus.rd_sel, bus.rd_port}), 64'({1'b1, 2'd2}));
    repeat (3) tick();
    chk("t3 L300 err", 64'({bus.len_err, bus.rd_done, bus.rd_done_port}), 64'({2'b11, 2'd2}));
    chk("t3 no frm 2", 64'(fq.size()), 64'd0);
    wait_done("t3 p1", 2'd1, 1'b0);
    chk_frame("t3 p1 frame", 1, 1);

    // Maximum length body on port 0.
    mem[0][0] = 18'd256;
    bus.rd_dmm_empty[0] = 1'b0;
    wait_done("t4 max", 2'd0, 1'b0);
    chk_frame("t4 frame", 0, 256);

    // Consumer not ready, then enable dropped mid-frame.
    repeat (3) tick();
    bus.frm_ready = 1'b0;
    mem[3][0] = 18'd2;
    bus.rd_dmm_empty = 4'b0111;
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.rd_sel === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("t5 held by frm_ready", 64'(seen), 64'd0);
    bus.frm_ready = 1'b1;
    tick();
    chk("t5 G-1 sel", 64'(bus.rd_sel), 64'd0);
    tick();
    chk("t5 G", 64'({bus.rd_sel, bus.rd_addr, bus.rd_port}), 64'({1'b1, 9'd0, 2'd3}));
    bus.enable = 1'b0;
    mem[1][0] = 18'd1;
    bus.rd_dmm_empty[1] = 1'b0;
    wait_done("t5 completes", 2'd3, 1'b0);
    chk_frame("t5 frame", 3, 2);
    seen = 0;
    repeat (12) begin
      tick();
      if (bus.rd_sel === 1'b1) seen++;
    end
    chk("t5 no new grant", 64'({bus.busy, 8'(seen)}), 64'd0);
    bus.enable = 1'b1;
    wait_done("t5 resume p1", 2'd1, 1'b0);
    chk_frame("t5 p1 frame", 1, 1);

    // Reset at body word 2 of an L = 5 frame.
    repeat (3) tick();
    mem[2][0] = 18'd5;
    bus.rd_dmm_empty[2] = 1'b0;
    tick();
    tick();
    chk("t6 G", 64'({bus.rd_sel, bus.rd_addr, bus.rd_port}), 64'({1'b1, 9'd0, 2'd2}));
    repeat (7) tick();
    chk("t6 word2", 64'({bus.frm_dval, bus.frm_sof, bus.frm_data}), 64'({2'b10, mem[2][2]}));
    rst_100m = 1'b1;
    tick();
    chk("t6 reset outputs", all_outs(), 64'd0);
    chk("t6 buffer kept", 64'(bus.rd_dmm_empty[2]), 64'd0);
    rst_100m = 1'b0;
    fq.delete();
    tick();
    chk("t6 re-read wait", 64'(bus.rd_sel), 64'd0);
    tick();
    chk("t6 re-read G", 64'({bus.rd_sel, bus.rd_addr, bus.rd_port}), 64'({1'b1, 9'd0, 2'd2}));
    wait_done("t6 done", 2'd2, 1'b0);
    chk_frame("t6 frame", 2, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
